// File: rtl/cei_mochila_pkg.sv
// System-level defaults for the hart arbiter: hart count, outstanding limit, hart-ID width.
package cei_mochila_pkg;

    localparam int unsigned NHartsDefault         = 3;
    localparam int unsigned MaxOutstandingDefault = 2;

    typedef enum logic {StIdle, StLocked} lock_state_e;

    // Width of a hart ID; never narrower than one bit.
    function automatic int unsigned hart_id_w(input int unsigned nharts);
        return (nharts > 1) ? $clog2(nharts) : 1;
    endfunction

endpackage

// File: rtl/obi_pkg.sv
// OBI request/response types shared by the cores, the hart arbiter and the system bus.
package obi_pkg;

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

endpackage

// File: rtl/obi_arb_id_fifo.sv
// Synchronous FIFO of hart IDs recording which hart owns each in-flight bus transaction.
module obi_arb_id_fifo #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [Width-1:0] wdata_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AddrW = $clog2(Depth);
    localparam int unsigned PtrW  = AddrW + 1;
    localparam int unsigned IdxW  = (Depth > 1) ? AddrW : 1;
    localparam logic [PtrW-1:0] DepthC = PtrW'(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
    logic [IdxW-1:0]  wr_idx, rd_idx;
    logic             push_ok, pop_ok;

    always_comb begin
        full_o  = (count_q == DepthC);
        empty_o = (count_q == '0);
        push_ok = push_i & ~full_o;
        pop_ok  = pop_i & ~empty_o;
        wr_idx  = IdxW'(32'(wr_ptr_q) % Depth);
        rd_idx  = IdxW'(32'(rd_ptr_q) % Depth);
        rdata_o = mem_q[rd_idx];

        mem_d = mem_q;
        if (push_ok) begin
            mem_d[wr_idx] = wdata_i;
        end

        wr_ptr_d = push_ok ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + PtrW'(1);
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - PtrW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/obi_hart_arbiter.sv
// Round-robin merge of per-hart OBI data ports onto one bus master with in-order response routing.
// Optional performance counters are built when OBI_ARB_PERF_EN is defined.
module obi_hart_arbiter
    import obi_pkg::*;
    import cei_mochila_pkg::*;
#(
    parameter int unsigned NHARTS          = NHartsDefault,
    parameter int unsigned MAX_OUTSTANDING = MaxOutstandingDefault
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  obi_req_t  [NHARTS-1:0]      hart_req_i,
    output obi_resp_t [NHARTS-1:0]      hart_resp_o,
    output obi_req_t                    bus_req_o,
    input  obi_resp_t                   bus_resp_i,
    output logic                        err_o
`ifdef OBI_ARB_PERF_EN
    ,
    output logic [NHARTS-1:0][31:0]     perf_grant_cnt_o,
    output logic [31:0]                 perf_stall_cnt_o
`endif
);

    localparam int unsigned IdW = hart_id_w(NHARTS);

    lock_state_e      state_q, state_d;
    logic [IdW-1:0]   ptr_q, ptr_d, lock_id_q, lock_id_d;
    logic [IdW-1:0]   rr_win, win, head, idx_l;
    logic [NHARTS-1:0] req_vec;
    logic             any_req, found, fifo_full, fifo_empty, handshake, pop;
    logic             err_q, err_d;
    int unsigned      idx;

    always_comb begin
        for (int i = 0; i < NHARTS; i++) begin
            req_vec[i] = hart_req_i[i].req;
        end
        any_req = |req_vec;

        found  = 1'b0;
        rr_win = ptr_q;
        idx    = 0;
        idx_l  = '0;
        for (int unsigned k = 0; k < NHARTS; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= NHARTS) begin
                idx = idx - NHARTS;
            end
            idx_l = IdW'(idx);
            if (!found && req_vec[idx_l]) begin
                found  = 1'b1;
                rr_win = idx_l;
            end
        end

        win = (state_q == StLocked) ? lock_id_q : rr_win;

        // A full FIFO blocks the request outright, even if a pop lands this cycle.
        bus_req_o = '0;
        if (any_req) begin
            bus_req_o     = hart_req_i[win];
            bus_req_o.req = ~fifo_full;
        end

        handshake = bus_req_o.req & bus_resp_i.gnt;
        pop       = bus_resp_i.rvalid & ~fifo_empty;
        err_d     = err_q | (bus_resp_i.rvalid & fifo_empty);

        hart_resp_o = '0;
        if (handshake) begin
            hart_resp_o[win].gnt = 1'b1;
        end
        if (pop) begin
            hart_resp_o[head].rvalid = 1'b1;
            hart_resp_o[head].rdata  = bus_resp_i.rdata;
        end

        ptr_d = ptr_q;
        if (handshake) begin
            ptr_d = (32'(win) == NHARTS - 1) ? '0 : win + IdW'(1);
        end

        state_d   = state_q;
        lock_id_d = lock_id_q;
        unique case (state_q)
            StIdle: begin
                if (bus_req_o.req && !bus_resp_i.gnt) begin
                    state_d   = StLocked;
                    lock_id_d = win;
                end
            end
            StLocked: begin
                if (handshake) begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            lock_id_q <= '0;
            ptr_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            lock_id_q <= lock_id_d;
            ptr_q     <= ptr_d;
            err_q     <= err_d;
        end
    end

    assign err_o = err_q;

    obi_arb_id_fifo #(
        .Depth(MAX_OUTSTANDING),
        .Width(IdW)
    ) u_id_fifo (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .push_i (handshake),
        .pop_i  (pop),
        .wdata_i(win),
        .rdata_o(head),
        .full_o (fifo_full),
        .empty_o(fifo_empty)
    );

`ifdef OBI_ARB_PERF_EN
    logic [NHARTS-1:0][31:0] grant_cnt_q, grant_cnt_d;
    logic [31:0]             stall_cnt_q, stall_cnt_d;

    always_comb begin
        grant_cnt_d = grant_cnt_q;
        if (handshake) begin
            grant_cnt_d[win] = grant_cnt_q[win] + 32'd1;
        end
        stall_cnt_d = stall_cnt_q + ((any_req && fifo_full) ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            grant_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            grant_cnt_q <= grant_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign perf_grant_cnt_o = grant_cnt_q;
    assign perf_stall_cnt_o = stall_cnt_q;
`endif

endmodule
